// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the table-memory arbiter.
// Bus widths come from the def.svh macros ADDR_BUS / DATA_BUS (defaults below).
`ifndef ADDR_BUS
`define ADDR_BUS 32
`endif
`ifndef DATA_BUS
`define DATA_BUS 32
`endif

package mem_arb_pkg;

  localparam int MEM_ARB_MAX_REQ = 8;
  localparam int ADDR_W = `ADDR_BUS;
  localparam int DATA_W = `DATA_BUS;
  localparam int IDX_W = 3;

  typedef logic [MEM_ARB_MAX_REQ-1:0] arb_vec_t;
  typedef logic [IDX_W-1:0] arb_idx_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_GAP
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-side and memory-side bus of mem_arbiter.
// Modports: slave (arbiter), master (requesters + memory model).
interface mem_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import mem_arb_pkg::*;

  logic [NUM_REQ-1:0] req_ce_i;
  logic [NUM_REQ-1:0] req_we_i;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ-1:0][3:0] req_width_i;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data_i;
  logic [NUM_REQ-1:0] req_grant_o;
  logic [DATA_W-1:0] req_data_o;

  logic mem_ce_o;
  logic mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [3:0] mem_width_o;
  logic [DATA_W-1:0] mem_data_o;
  logic [DATA_W-1:0] mem_data_i;

  modport slave (
    input  req_ce_i, req_we_i, req_addr_i,
    input  req_width_i, req_data_i, mem_data_i,
    output req_grant_o, req_data_o,
    output mem_ce_o, mem_we_o, mem_addr_o,
    output mem_width_o, mem_data_o
  );

  modport master (
    output req_ce_i, req_we_i, req_addr_i,
    output req_width_i, req_data_i, mem_data_i,
    input  req_grant_o, req_data_o,
    input  mem_ce_o, mem_we_o, mem_addr_o,
    input  mem_width_o, mem_data_o
  );

endinterface

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick, searching from last_i+1.
// Ports: req_i, last_i in; win_o (one-hot), idx_o, valid_o out.
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  arb_idx_t           last_i,
  output logic [NUM_REQ-1:0] win_o,
  output arb_idx_t           idx_o,
  output logic               valid_o
);

  always_comb begin
    win_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!valid_o && req_i[i] &&
            i == (int'(last_i) + k) % NUM_REQ) begin
          valid_o  = 1'b1;
          idx_o    = arb_idx_t'(i);
          win_o[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin, burst-locked owner of the single table-memory port.
// Ports: clk, rst (sync, high), bus (mem_arbiter_if.slave), timeout_o.
// Optional grant-hold timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 256
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus,
  output logic         timeout_o
);

  arb_state_t state_q, state_d;
  arb_idx_t   owner_q, owner_d;
  arb_idx_t   last_q, last_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] req_eff;
  logic [NUM_REQ-1:0] pick_win;
  arb_idx_t pick_idx;
  logic     pick_vld;

  logic              own_ce, own_we;
  logic [ADDR_W-1:0] own_addr;
  logic [3:0]        own_width;
  logic [DATA_W-1:0] own_data;
  logic              in_grant;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [15:0]        hold_q, hold_d;
  logic [NUM_REQ-1:0] mask_q, mask_d;
  logic               tmo_q, tmo_d;

  // A revoked requester sits out until it lets go of ce.
  assign req_eff   = bus.req_ce_i & ~mask_q;
  assign timeout_o = tmo_q;
`else
  assign req_eff   = bus.req_ce_i;
  // Hold limit only matters in the timeout build.
  assign timeout_o = (MAX_HOLD < 0);
`endif

  rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i   (req_eff),
    .last_i  (last_q),
    .win_o   (pick_win),
    .idx_o   (pick_idx),
    .valid_o (pick_vld)
  );

  always_comb begin
    own_ce    = 1'b0;
    own_we    = 1'b0;
    own_addr  = '0;
    own_width = '0;
    own_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == arb_idx_t'(i)) begin
        own_ce    = bus.req_ce_i[i];
        own_we    = bus.req_we_i[i];
        own_addr  = bus.req_addr_i[i];
        own_width = bus.req_width_i[i];
        own_data  = bus.req_data_i[i];
      end
    end
  end

  assign in_grant        = (state_q == ARB_GRANT);
  assign bus.mem_ce_o    = in_grant & own_ce;
  assign bus.mem_we_o    = in_grant & own_we;
  assign bus.mem_addr_o  = in_grant ? own_addr : '0;
  assign bus.mem_width_o = in_grant ? own_width : '0;
  assign bus.mem_data_o  = in_grant ? own_data : '0;
  assign bus.req_data_o  = bus.mem_data_i;
  assign bus.req_grant_o = grant_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    grant_d = grant_q;
`ifdef MEM_ARB_TIMEOUT_EN
    hold_d = hold_q;
    mask_d = mask_q & bus.req_ce_i;
    tmo_d  = 1'b0;
`endif
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_vld) begin
          state_d = ARB_GRANT;
          owner_d = pick_idx;
          last_d  = pick_idx;
          grant_d = pick_win;
`ifdef MEM_ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      ARB_GRANT: begin
        if (!own_ce) begin
          grant_d = '0;
          state_d = ARB_GAP;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (hold_q == 16'(MAX_HOLD - 1)) begin
          grant_d = '0;
          state_d = ARB_GAP;
          tmo_d   = 1'b1;
          mask_d  = mask_d | grant_q;
        end else begin
          hold_d = hold_q + 16'd1;
        end
`endif
      end
      ARB_GAP: state_d = ARB_IDLE;
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      last_q  <= arb_idx_t'(NUM_REQ - 1);
      grant_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      hold_q  <= '0;
      mask_q  <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      grant_q <= grant_d;
`ifdef MEM_ARB_TIMEOUT_EN
      hold_q  <= hold_d;
      mask_q  <= mask_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

endmodule
